rb_mult_issue_ctrl: RTL
=======================

// Module: rb_mult_issue_ctrl
// PURPOSE
//  Operand-issue and product-capture controller for the combinational row-bypass array multiplier.
//  Registers a/b on a valid/ready handshake and holds them stable for SETTLE_CYCLES clocks.
//  Captures the product and presents it on a valid/ready output.
//  Zero operands bypass the multiplier entirely; mult_a/mult_b are never toggled, for low power.
// PARAMETERS
//  M              64  width of operand a (multiplier a input)
//  N              64  width of operand b (multiplier b input)
//  SETTLE_CYCLES  4   clocks the multiplier is given to settle; legal range 1..255
// PORTS
//  clk           in   1      single clock; all state updates on the rising edge
//  rst           in   1      asynchronous, active-high reset
//  in_valid      in   1      operand pair valid
//  in_ready      out  1      controller can accept an operand pair this cycle
//  in_a          in   M      operand a
//  in_b          in   N      operand b
//  mult_a        out  M      registered operand a, drives the multiplier a input
//  mult_b        out  N      registered operand b, drives the multiplier b input
//  mult_product  in   M+N    product from the multiplier (combinational)
//  out_valid     out  1      out_product valid
//  out_ready     in   1      consumer accepts out_product
//  out_product   out  M+N    captured product
//  busy          out  1      high in SETTLE state
// BEHAVIOUR
//  Reset (async, immediate on rst=1):
//   - state=IDLE, cnt=0.
//   - mult_a=0, mult_b=0, out_product=0, out_valid=0, busy=0.
//   - in_ready=0 while rst is high.
//  States:
//   - IDLE: in_ready=1.
//   - SETTLE: in_ready=0, busy=1.
//   - HOLD: out_valid=1; in_ready=out_ready (combinational).
//  Accept = in_valid & in_ready at a rising edge.
//  On accept of a non-zero pair (in_a!=0 and in_b!=0):
//   - mult_a<=in_a, mult_b<=in_b, cnt<=SETTLE_CYCLES-1, state<=SETTLE.
//   - out_valid<=0 when the accept happens from HOLD.
//  On accept of a zero pair (in_a==0 or in_b==0):
//   - mult_a/mult_b keep their old values.
//   - out_product<=0, state<=HOLD, out_valid<=1.
//  SETTLE:
//   - At each edge: if cnt==0, then out_product<=mult_product, out_valid<=1, state<=HOLD.
//   - Otherwise cnt<=cnt-1.
//   - in_valid is ignored.
//  Latency (counted from the accept edge E0):
//   - non-zero pair: capture at edge E0+SETTLE_CYCLES; out_valid high after that edge.
//   - zero pair: out_valid high after E0.
//  HOLD:
//   - out_product and out_valid are stable until out_ready=1 at an edge.
//   - out_ready=1 with no accept: state<=IDLE, out_valid<=0.
//   - out_ready=1 together with an accept (back-to-back): the accept rules above apply in the same edge.
//  mult_a/mult_b change only on a non-zero accept.
//  mult_product is sampled only at the capture edge.
//  Reset mid-SETTLE or mid-HOLD: the operation is abandoned and all registers return to reset values.
//  cnt width = clog2(SETTLE_CYCLES)+1.
// TESTING
//  1. M=N=8, S=4: accept a=0x0F, b=0x11 at E0.
//     -> busy high for 4 edges; out_product=0x00FF after E0+4; mult_a/mult_b hold 0x0F/0x11.
//  2. a=0x00, b=0xAB.
//     -> out_valid after E0, out_product=0; mult_a/mult_b unchanged from the previous op.
//  3. out_ready low for 5 cycles in HOLD.
//     -> out_product and out_valid stable; in_ready=0; a new in_valid is not accepted.
//  4. Back-to-back: out_ready=1 and in_valid=1 in HOLD with a=0xFF, b=0xFF.
//     -> same-edge accept; out_product=0xFE01 after 4 more edges.
//  5. S=1: a=3, b=5.
//     -> out_product=15, out_valid after E0+1.
//  6. Assert rst asynchronously during SETTLE (cnt=2).
//     -> out_valid=0, mult_a=0, mult_b=0, busy=0 immediately; IDLE after release.

Source files
------------

// File: rtl/rb_mult_issue_ctrl.sv
// Operand-issue / product-capture controller for a combinational row-bypass array multiplier.
// Holds operands stable while the array settles; zero operands short-circuit to a zero product.
module rb_mult_issue_ctrl #(
    parameter int M             = 64,
    parameter int N             = 64,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [M-1:0]   in_a,
    input  logic [N-1:0]   in_b,
    output logic [M-1:0]   mult_a,
    output logic [N-1:0]   mult_b,
    input  logic [M+N-1:0] mult_product,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [M+N-1:0] out_product,
    output logic           busy
);
    localparam int CW = $clog2(SETTLE_CYCLES) + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_HOLD   = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          zero_pair;

    // HOLD can take a new pair in the same edge the result is consumed.
    assign in_ready  = !rst && ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign busy      = (state == S_SETTLE);
    assign accept    = in_valid && in_ready;
    assign zero_pair = (in_a == '0) || (in_b == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            mult_a      <= '0;
            mult_b      <= '0;
            out_product <= '0;
            out_valid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        if (zero_pair) begin
                            // Leave mult_a/mult_b alone so the array does not toggle.
                            out_product <= '0;
                            out_valid   <= 1'b1;
                            state       <= S_HOLD;
                        end else begin
                            mult_a    <= in_a;
                            mult_b    <= in_b;
                            cnt       <= CW'(SETTLE_CYCLES - 1);
                            out_valid <= 1'b0;
                            state     <= S_SETTLE;
                        end
                    end else if ((state == S_HOLD) && out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                S_SETTLE: begin
                    if (cnt == '0) begin
                        out_product <= mult_product;
                        out_valid   <= 1'b1;
                        state       <= S_HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
